// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter_if
// Brief    : Producer handshake and FIFO write-side bundle for fifo_wr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================

interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          wr_en;
  logic [FIFO_WIDTH-1:0]         data_in;
  logic                          full;
  logic                          almostfull;
  logic                          wr_ack;
  logic                          overflow;
  logic                          err_ack;
  logic                          err_ovf;

  // Producers plus FIFO as seen from outside the arbiter
  modport master (
    output req, req_data, full, almostfull, wr_ack, overflow,
    input  gnt, wr_en, data_in, err_ack, err_ovf
  );

  modport slave (
    input  req, req_data, full, almostfull, wr_ack, overflow,
    output gnt, wr_en, data_in, err_ack, err_ovf
  );

endinterface

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter sharing one FIFO write port among
//            NUM_REQ producers. Define FIFO_ARB_STATS_EN for word/stall counters.
// Revision : 1.0 - initial release
// ============================================================================

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef FIFO_ARB_STATS_EN
  output logic [15:0]      stat_words,
  output logic [15:0]      stat_stall,
`endif
  fifo_wr_arbiter_if.slave bus
);

  localparam int                 c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0]         c_BURST = 4'(BURST_LEN);
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_PTR_W-1:0]    r_rr_ptr;
  logic [c_PTR_W-1:0]    w_rr_ptr_nxt;
  logic [c_PTR_W-1:0]    r_owner;
  logic [c_PTR_W-1:0]    w_owner_nxt;
  logic [3:0]            r_burst_cnt;
  logic [3:0]            w_burst_cnt_nxt;

  logic                  r_run;
  logic                  r_wr_en;
  logic [FIFO_WIDTH-1:0] r_data;
  logic                  r_ack_pend;
  logic                  r_err_ack;
  logic                  r_err_ovf;

  logic                  w_can_issue;
  logic                  w_own_req;
  logic                  w_found;
  logic                  w_accept;
  logic [c_PTR_W-1:0]    w_base;
  logic [c_PTR_W-1:0]    w_idx;
  logic [c_PTR_W-1:0]    w_cand;
  logic [3:0]            w_new_cnt;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [FIFO_WIDTH-1:0] w_words [NUM_REQ];

  function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] idx);
    return (idx == c_LAST) ? '0 : idx + 1'b1;
  endfunction

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign w_words[gi] = bus.req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
  end

  // A registered write still in flight takes the last slot under almostfull
  assign w_can_issue = !bus.full && !(bus.almostfull && r_wr_en);
  assign w_own_req   = bus.req[r_owner];

  // Owner keeps priority while requesting; once it drops, search resumes past it
  always_comb begin
    w_base = r_rr_ptr;
    if (r_state == BURST) begin
      w_base = w_own_req ? r_owner : f_next(r_owner);
    end
    w_found = 1'b0;
    w_cand  = '0;
    w_idx   = w_base;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_cand  = w_idx;
      end
      w_idx = f_next(w_idx);
    end
  end

  // r_run keeps grants off until the first edge after reset release
  assign w_accept  = r_run && w_can_issue && w_found;
  assign w_new_cnt = (r_state == BURST && w_own_req) ? r_burst_cnt + 4'd1 : 4'd1;

  always_comb begin
    w_gnt = '0;
    if (w_accept) begin
      w_gnt[w_cand] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = r_burst_cnt;
    if (w_accept) begin
      w_owner_nxt = w_cand;
      if (w_new_cnt >= c_BURST) begin
        w_state_nxt     = IDLE;
        w_rr_ptr_nxt    = f_next(w_cand);
        w_burst_cnt_nxt = '0;
      end else begin
        w_state_nxt     = BURST;
        w_burst_cnt_nxt = w_new_cnt;
      end
    end else if (r_state == BURST && !w_own_req) begin
      w_state_nxt     = IDLE;
      w_rr_ptr_nxt    = f_next(r_owner);
      w_burst_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_wr_en    <= 1'b0;
      r_data     <= '0;
      r_ack_pend <= 1'b0;
      r_err_ack  <= 1'b0;
      r_err_ovf  <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_wr_en    <= w_accept;
      r_ack_pend <= r_wr_en;
      if (w_accept) begin
        r_data <= w_words[w_cand];
      end
      if (r_ack_pend && !bus.wr_ack) begin
        r_err_ack <= 1'b1;
      end
      if (bus.overflow) begin
        r_err_ovf <= 1'b1;
      end
    end
  end

  assign bus.gnt     = w_gnt;
  assign bus.wr_en   = r_wr_en;
  assign bus.data_in = r_data;
  assign bus.err_ack = r_err_ack;
  assign bus.err_ovf = r_err_ovf;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] r_stat_words;
  logic [15:0] r_stat_stall;
  logic        w_stall;

  assign w_stall = (|bus.req) && !w_can_issue;

  // Both counters saturate rather than wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_words <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_accept && r_stat_words != 16'hFFFF) begin
        r_stat_words <= r_stat_words + 16'd1;
      end
      if (w_stall && r_stat_stall != 16'hFFFF) begin
        r_stat_stall <= r_stat_stall + 16'd1;
      end
    end
  end

  assign stat_words = r_stat_words;
  assign stat_stall = r_stat_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Self-checking bench for fifo_wr_arbiter (vector table, directed
//            corner sequences, randomized run against a reference model).
// Revision : 1.0 - initial release
// ============================================================================

module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .FIFO_WIDTH(W)) bus ();

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_words;
  logic [15:0] stat_stall;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .FIFO_WIDTH(W),
    .BURST_LEN (BL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FIFO_ARB_STATS_EN
    .stat_words(stat_words),
    .stat_stall(stat_stall),
`endif
    .bus       (bus)
  );

  int   n_total = 0;
  int   n_pass  = 0;
  logic last_wr_en;
  logic suppress_ack;
  logic [W-1:0] exp_data;

  typedef struct {
    logic [N-1:0] req;
    logic         full;
    logic         af;
    logic [N-1:0] gnt;
    logic         wr_en;
    int           src;   // requester whose word lands in data_in, -1 = hold
  } vec_t;

  vec_t tbl [18];

  // Reference model state: owner -1 means nobody holds a burst
  int           m_owner;
  int           m_cnt;
  int           m_ptr;
  logic         m_wr_en;
  logic         m_first;
  logic [W-1:0] m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] word(input int i, input int v);
    return W'(32'hA000 + i * 256 + v);
  endfunction

  task automatic set_data(input int v);
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = word(i, v);
  endtask

  // One clock: check gnt mid-cycle, cross the edge, act as the FIFO's wr_ack
  task automatic step(input string tag, input logic chk_gnt, input logic [N-1:0] exp_gnt);
    @(negedge clk);
    if (chk_gnt) check({tag, " gnt"}, 32'(bus.gnt), 32'(exp_gnt));
    @(posedge clk);
    #1;
    bus.wr_ack = last_wr_en & ~suppress_ack;
    last_wr_en = bus.wr_en;
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    bus.req        = r;
    bus.full       = 1'b0;
    bus.almostfull = 1'b0;
    bus.wr_ack     = 1'b0;
    bus.overflow   = 1'b0;
    suppress_ack   = 1'b0;
    last_wr_en     = 1'b0;
    set_data(0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst gnt", 32'(bus.gnt), 32'd0);
    check("rst wr_en", 32'(bus.wr_en), 32'd0);
    check("rst data_in", 32'(bus.data_in), 32'd0);
    check("rst err_ack", 32'(bus.err_ack), 32'd0);
    check("rst err_ovf", 32'(bus.err_ovf), 32'd0);
    rst_n = 1'b1;
  endtask

  function automatic int m_pick(input logic [N-1:0] r);
    int start;
    if (m_owner >= 0 && r[m_owner]) return m_owner;
    start = (m_owner >= 0) ? (m_owner + 1) % N : m_ptr;
    for (int k = 0; k < N; k++) if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //          req      full  af    gnt      wr_en src
    tbl[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, -1};
    tbl[1]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1,  0};
    tbl[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1,  0};
    tbl[3]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1,  0};
    tbl[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1,  0};
    tbl[5]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1,  1};
    tbl[6]  = '{4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1,  1};
    tbl[7]  = '{4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1,  3};
    tbl[8]  = '{4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1,  3};
    tbl[9]  = '{4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1,  3};
    tbl[10] = '{4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1,  3};
    tbl[11] = '{4'b1001, 1'b0, 1'b0, 4'b0001, 1'b1,  0};
    tbl[12] = '{4'b1001, 1'b0, 1'b1, 4'b0000, 1'b0, -1};
    tbl[13] = '{4'b1001, 1'b0, 1'b1, 4'b0001, 1'b1,  0};
    tbl[14] = '{4'b1001, 1'b0, 1'b0, 4'b0001, 1'b1,  0};
    tbl[15] = '{4'b1001, 1'b1, 1'b0, 4'b0000, 1'b0, -1};
    tbl[16] = '{4'b1001, 1'b0, 1'b0, 4'b0001, 1'b1,  0};
    tbl[17] = '{4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1,  3};

    // Vector table: burst rotation, owner drop, almostfull and full throttling
    do_reset(4'b1111);
    exp_data = '0;
    for (int v = 0; v < 18; v++) begin
      bus.req        = tbl[v].req;
      bus.full       = tbl[v].full;
      bus.almostfull = tbl[v].af;
      set_data(v);
      step($sformatf("vec%0d", v), 1'b1, tbl[v].gnt);
      if (tbl[v].src >= 0) exp_data = word(tbl[v].src, v);
      check($sformatf("vec%0d wr_en", v), 32'(bus.wr_en), 32'(tbl[v].wr_en));
      check($sformatf("vec%0d data_in", v), 32'(bus.data_in), 32'(exp_data));
    end
    bus.full       = 1'b0;
    bus.almostfull = 1'b0;
    check("table err_ovf", 32'(bus.err_ovf), 32'd0);
    check("table err_ack", 32'(bus.err_ack), 32'd0);

    // Single requester: nine back-to-back words across two rotations
    do_reset(4'b0100);
    step("single idle", 1'b1, 4'b0000);
    for (int k = 0; k < 9; k++) begin
      bus.req_data[2*W +: W] = W'(16'h00C1 + k);
      step($sformatf("single%0d", k), 1'b1, 4'b0100);
      check($sformatf("single%0d wr_en", k), 32'(bus.wr_en), 32'd1);
      check($sformatf("single%0d data_in", k), 32'(bus.data_in), 32'(16'h00C1 + k));
    end
    bus.req = '0;
    step("single end", 1'b1, 4'b0000);
    check("single end wr_en", 32'(bus.wr_en), 32'd0);

    // Missing wr_ack, overflow pulse, then reset in the middle of a burst
    do_reset(4'b0000);
    step("err idle", 1'b0, '0);
    bus.req = 4'b0001;
    step("err write", 1'b1, 4'b0001);
    bus.req      = '0;
    suppress_ack = 1'b1;
    step("err pend", 1'b0, '0);
    check("err_ack before", 32'(bus.err_ack), 32'd0);
    suppress_ack = 1'b0;
    step("err miss", 1'b0, '0);
    check("err_ack set", 32'(bus.err_ack), 32'd1);
    bus.overflow = 1'b1;
    step("ovf pulse", 1'b0, '0);
    bus.overflow = 1'b0;
    check("err_ovf set", 32'(bus.err_ovf), 32'd1);
    step("ovf hold", 1'b0, '0);
    check("err_ovf sticky", 32'(bus.err_ovf), 32'd1);
    check("err_ack sticky", 32'(bus.err_ack), 32'd1);
    bus.req = 4'b0100;
    step("mid b0", 1'b1, 4'b0100);
    step("mid b1", 1'b1, 4'b0100);
    check("mid wr_en", 32'(bus.wr_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst wr_en", 32'(bus.wr_en), 32'd0);
    check("mid rst gnt", 32'(bus.gnt), 32'd0);
    check("mid rst err_ack", 32'(bus.err_ack), 32'd0);
    check("mid rst err_ovf", 32'(bus.err_ovf), 32'd0);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    last_wr_en   = 1'b0;
    bus.wr_ack   = 1'b0;
    bus.req      = 4'b1111;
    set_data(0);
    step("post rst idle", 1'b1, 4'b0000);
    step("post rst first", 1'b1, 4'b0001);
    check("post rst data_in", 32'(bus.data_in), 32'(word(0, 0)));

`ifdef FIFO_ARB_STATS_EN
    do_reset(4'b0001);
    step("stat idle", 1'b0, '0);
    for (int k = 0; k < 13; k++) begin
      bus.full = (k == 3 || k == 7 || k == 11);
      step("stat", 1'b0, '0);
    end
    bus.full = 1'b0;
    bus.req  = '0;
    step("stat end", 1'b0, '0);
    check("stat_words", 32'(stat_words), 32'd10);
    check("stat_stall", 32'(stat_stall), 32'd3);
`endif

    // Randomized traffic against the reference model
    do_reset(4'b0000);
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = 0;
    m_wr_en = 1'b0;
    m_first = 1'b1;
    m_data  = '0;
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] r;
      logic [N-1:0] eg;
      logic         can;
      int           g;
      r = bus.req;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
      bus.req        = r;
      bus.full       = ($urandom_range(0, 9) == 0);
      bus.almostfull = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = W'($urandom);
      g   = m_pick(r);
      can = !m_first && !bus.full && !(bus.almostfull && m_wr_en);
      eg  = (can && g >= 0) ? N'(1 << g) : '0;
      if (eg != '0) begin
        m_cnt   = (g == m_owner) ? m_cnt + 1 : 1;
        m_owner = g;
        m_wr_en = 1'b1;
        m_data  = bus.req_data[g*W +: W];
        if (m_cnt >= BL) begin
          m_ptr   = (g + 1) % N;
          m_owner = -1;
        end
      end else begin
        m_wr_en = 1'b0;
        if (m_owner >= 0 && !r[m_owner]) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
      m_first = 1'b0;
      step($sformatf("rand%0d", c), 1'b1, eg);
      check($sformatf("rand%0d wr_en", c), 32'(bus.wr_en), 32'(m_wr_en));
      check($sformatf("rand%0d data_in", c), 32'(bus.data_in), 32'(m_data));
    end
    check("rand err_ack", 32'(bus.err_ack), 32'd0);
    check("rand err_ovf", 32'(bus.err_ovf), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one synchronous FIFO between NUM_REQ producers.
- Each producer uses a req/gnt valid-ready handshake; the arbiter drives the FIFO wr_en/data_in from registers.
- Throttles on full/almostfull so the FIFO never overflows, and cross-checks the FIFO's wr_ack/overflow responses.
- Sits between producer blocks and the FIFO write side; read side untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- FIFO_WIDTH, 16, data word width
- BURST_LEN, 4, max consecutive accepts from one requester before forced rotation (1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester valid; requester i holds word on req_data slice i while req[i]=1
- req_data  in  NUM_REQ*FIFO_WIDTH  packed words, slice i = bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- gnt  out  NUM_REQ  combinational one-hot ready; word i taken at the rising edge where req[i]&gnt[i]
- wr_en  out  1  registered FIFO write enable
- data_in  out  FIFO_WIDTH  registered FIFO write data
- full  in  1  FIFO full
- almostfull  in  1  FIFO one slot from full
- wr_ack  in  1  FIFO write acknowledge, one cycle after accepted write
- overflow  in  1  FIFO overflow flag
- err_ack  out  1  sticky: wr_ack missing after an issued write
- err_ovf  out  1  sticky: FIFO reported overflow

Behaviour:
- Reset (async, rst_n=0): wr_en=0, data_in=0, gnt=0, err_ack=0, err_ovf=0, state=IDLE, rr_ptr=0, burst_cnt=0, ack_pend=0. Outputs stay there until the first clk edge after deassertion.
- can_issue = !full && !(almostfull && wr_en). A registered write in flight consumes the last slot.
- Arbitration:
  - Candidate = first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - gnt = onehot(candidate) when can_issue, else 0.
- States:
  - IDLE: no owner. On accept, go to BURST, set owner=candidate, burst_cnt=1.
  - BURST: the candidate is forced to owner while req[owner]=1.
    - Accept while burst_cnt<BURST_LEN: burst_cnt+1.
    - Accept when burst_cnt reaches BURST_LEN, or req[owner]=0: rr_ptr=(owner+1) mod NUM_REQ, go to IDLE.
    - Re-arbitration happens in the same cycle, so there are no bubbles between owners.
    - Stall (can_issue=0) holds state and burst_cnt.
- Datapath: on accept, wr_en<=1 and data_in<=selected word. Otherwise wr_en<=0 and data_in holds its value.
- Latency: req/gnt edge to FIFO write edge is 1 cycle. Throughput is 1 word/cycle while space remains.
- ack_pend<=wr_en each cycle. If ack_pend=1 and wr_ack=0, err_ack<=1.
- overflow=1 sets err_ovf<=1.
- err_ack and err_ovf clear only on reset.
- Single requester: always granted, rotation is a no-op.
- rr_ptr wrap: NUM_REQ-1 wraps to 0.
- Reset mid-burst: the in-flight write is dropped (wr_en forced 0), ownership is lost, and the next arbitration starts at requester 0.

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- Defined: adds 16-bit outputs stat_words (total accepts) and stat_stall (cycles with |req=1 and can_issue=0). Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset with all req=1, then release: first gnt=4'b0001. Data A0..A3 are written on 4 consecutive edges, then gnt moves to 4'b0010.
- Only req[2]=1 with data 16'h00C1..16'h00C9 (9 words): 9 writes with no gaps; rr_ptr rotates after words 4 and 8. gnt stays 4'b0100 for all 9 cycles.
- almostfull=1 while a write is in flight: gnt=0 for that cycle and wr_en=0 the next cycle. Release almostfull, then writing resumes, err_ovf=0.
- req[1] drops after 2 words with req[3]=1: the next cycle grants requester 3, and burst_cnt restarts at 1.
- Bench suppresses wr_ack after a write: err_ack=1 one cycle later and stays set. Pulsing overflow sets err_ovf=1. rst_n=0 mid-burst clears both and wr_en=0 immediately.
- With FIFO_ARB_STATS_EN: 10 accepts plus 3 full-stall cycles give stat_words=10 and stat_stall=3.
